// File: rtl/uart_wb_pkg.sv
// Shared constants and FSM encoding for the UART-to-Wishbone master bridge.
// UART_WB_PARITY_EN selects 11-bit frames with even parity instead of 8N1.
package uart_wb_pkg;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ST_OK  = 8'h4B;
  localparam logic [7:0] ST_ERR = 8'h45;

`ifdef UART_WB_PARITY_EN
  localparam int unsigned UART_FRAME_BITS = 11;
`else
  localparam int unsigned UART_FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } bridge_state_t;

endpackage

// File: rtl/uart_wb_phy.sv
// UART physical layer: rx synchroniser, rx/tx shifters and baud counters.
// UART_WB_PARITY_EN adds an even parity bit after the data bits in both directions.
module uart_wb_phy
  import uart_wb_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLK_DIV - 1);
  localparam logic [3:0]    STOP_IDX = 4'(UART_FRAME_BITS - 1);
  localparam int TXW = UART_FRAME_BITS - 1;

  logic          rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic          rx_busy_reg;
  logic [CW-1:0] rx_cnt_reg;
  logic [3:0]    rx_bit_reg;
  logic [7:0]    rx_shift_reg;
  logic          rx_valid_reg, rx_err_reg;
  logic          rx_par_ok;

  logic           tx_busy_reg, tx_line_reg;
  logic [CW-1:0]  tx_cnt_reg;
  logic [3:0]     tx_bit_reg;
  logic [TXW-1:0] tx_frame_reg;

`ifdef UART_WB_PARITY_EN
  logic rx_par_reg;
  assign rx_par_ok = (rx_par_reg == ^rx_shift_reg);
`else
  assign rx_par_ok = 1'b1;
`endif

  // Bit index 0 is the start bit, sampled at mid-bit; later bits follow every CLK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_prev_reg  <= 1'b1;
      rx_busy_reg  <= 1'b0;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_valid_reg <= 1'b0;
      rx_err_reg   <= 1'b0;
`ifdef UART_WB_PARITY_EN
      rx_par_reg   <= 1'b0;
`endif
    end else begin
      rx_meta_reg  <= uart_rx;
      rx_sync_reg  <= rx_meta_reg;
      rx_prev_reg  <= rx_sync_reg;
      rx_valid_reg <= 1'b0;
      rx_err_reg   <= 1'b0;
      if (!rx_busy_reg) begin
        if (rx_prev_reg && !rx_sync_reg) begin
          rx_busy_reg <= 1'b1;
          rx_cnt_reg  <= '0;
          rx_bit_reg  <= '0;
        end
      end else if (rx_bit_reg == 4'd0) begin
        if (rx_cnt_reg == HALF_M1) begin
          if (rx_sync_reg) begin
            rx_busy_reg <= 1'b0;
          end else begin
            rx_cnt_reg <= '0;
            rx_bit_reg <= 4'd1;
          end
        end else begin
          rx_cnt_reg <= rx_cnt_reg + CW'(1);
        end
      end else if (rx_cnt_reg == FULL_M1) begin
        rx_cnt_reg <= '0;
        rx_bit_reg <= rx_bit_reg + 4'd1;
        if (rx_bit_reg == STOP_IDX) begin
          rx_busy_reg <= 1'b0;
          if (rx_sync_reg && rx_par_ok) rx_valid_reg <= 1'b1;
          else rx_err_reg <= 1'b1;
        end else if (rx_bit_reg <= 4'd8) begin
          rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
        end
`ifdef UART_WB_PARITY_EN
        else begin
          rx_par_reg <= rx_sync_reg;
        end
`endif
      end else begin
        rx_cnt_reg <= rx_cnt_reg + CW'(1);
      end
    end
  end

  assign rx_data  = rx_shift_reg;
  assign rx_valid = rx_valid_reg;
  assign rx_err   = rx_err_reg;

  // The line register already shows the start bit; the frame holds what follows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_reg  <= 1'b0;
      tx_line_reg  <= 1'b1;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_frame_reg <= '1;
    end else if (!tx_busy_reg) begin
      if (tx_start) begin
        tx_busy_reg <= 1'b1;
        tx_line_reg <= 1'b0;
        tx_cnt_reg  <= '0;
        tx_bit_reg  <= '0;
`ifdef UART_WB_PARITY_EN
        tx_frame_reg <= {1'b1, ^tx_data, tx_data};
`else
        tx_frame_reg <= {1'b1, tx_data};
`endif
      end
    end else if (tx_cnt_reg == FULL_M1) begin
      tx_cnt_reg <= '0;
      if (tx_bit_reg == STOP_IDX) begin
        tx_busy_reg <= 1'b0;
        tx_line_reg <= 1'b1;
      end else begin
        tx_line_reg  <= tx_frame_reg[0];
        tx_frame_reg <= {1'b1, tx_frame_reg[TXW-1:1]};
        tx_bit_reg   <= tx_bit_reg + 4'd1;
      end
    end else begin
      tx_cnt_reg <= tx_cnt_reg + CW'(1);
    end
  end

  assign uart_tx = tx_line_reg;
  assign tx_busy = tx_busy_reg;

endmodule

// File: rtl/uart_wb_master_bridge.sv
// UART command frames in, one Wishbone read/write with ack timeout, status/data bytes out.
// UART_WB_PARITY_EN (in uart_wb_phy) switches the link to even-parity 11-bit frames.
module uart_wb_master_bridge
  import uart_wb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int CLK_DIV        = 434,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    uart_rx,
  output logic                    uart_tx,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  output logic                    busy_o
);

  localparam int DBYTES = DATA_WIDTH / 8;
  localparam int ABYTES = ADDR_WIDTH / 8;
  localparam int MAXB   = (ABYTES > DBYTES) ? ABYTES : DBYTES;
  localparam int IDX_W  = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RIDX_W = $clog2(DBYTES + 2);

  logic [7:0] rx_data, tx_byte;
  logic       rx_valid, rx_err, tx_start, tx_busy;

  bridge_state_t             state_reg, state_next;
  logic                      is_read_reg, is_read_next;
  logic [IDX_W-1:0]          byte_idx_reg, byte_idx_next;
  logic [ADDR_WIDTH-1:0]     adr_reg, adr_next;
  logic [DATA_WIDTH-1:0]     wdat_reg, wdat_next;
  logic [DATA_WIDTH-1:0]     rdat_reg, rdat_next;
  logic [7:0]                status_reg, status_next;
  logic [TO_W-1:0]           to_cnt_reg, to_cnt_next;
  logic [RIDX_W-1:0]         resp_idx_reg, resp_idx_next, resp_last;
  logic                      tx_launched_reg, tx_launched_next;

  uart_wb_phy #(
    .CLK_DIV (CLK_DIV)
  ) u_phy (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .tx_data  (tx_byte),
    .tx_start (tx_start),
    .tx_busy  (tx_busy)
  );

  // Response byte 0 is the status; bytes 1..DBYTES are read data, LSB first.
  assign resp_last = (is_read_reg && status_reg == ST_OK) ? RIDX_W'(DBYTES) : '0;
  assign tx_byte   = (resp_idx_reg == '0) ? status_reg
                   : 8'(rdat_reg >> (8 * (resp_idx_reg - RIDX_W'(1))));

  always_comb begin
    state_next       = state_reg;
    is_read_next     = is_read_reg;
    byte_idx_next    = byte_idx_reg;
    adr_next         = adr_reg;
    wdat_next        = wdat_reg;
    rdat_next        = rdat_reg;
    status_next      = status_reg;
    to_cnt_next      = to_cnt_reg;
    resp_idx_next    = resp_idx_reg;
    tx_launched_next = 1'b0;
    tx_start         = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (rx_valid) begin
          byte_idx_next = '0;
          resp_idx_next = '0;
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            is_read_next = (rx_data == CMD_RD);
            state_next   = S_ADDR;
          end else begin
            is_read_next = 1'b0;
            status_next  = ST_ERR;
            state_next   = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (rx_err) begin
          status_next = ST_ERR;
          state_next  = S_RESP;
        end else if (rx_valid) begin
          adr_next[byte_idx_reg*8 +: 8] = rx_data;
          if (byte_idx_reg == IDX_W'(ABYTES - 1)) begin
            byte_idx_next = '0;
            to_cnt_next   = '0;
            state_next    = is_read_reg ? S_BUS : S_DATA;
          end else begin
            byte_idx_next = byte_idx_reg + IDX_W'(1);
          end
        end
      end
      S_DATA: begin
        if (rx_err) begin
          status_next = ST_ERR;
          state_next  = S_RESP;
        end else if (rx_valid) begin
          wdat_next[byte_idx_reg*8 +: 8] = rx_data;
          if (byte_idx_reg == IDX_W'(DBYTES - 1)) begin
            byte_idx_next = '0;
            to_cnt_next   = '0;
            state_next    = S_BUS;
          end else begin
            byte_idx_next = byte_idx_reg + IDX_W'(1);
          end
        end
      end
      S_BUS: begin
        // Ack wins over an expiring count in the same cycle.
        if (wb_ack_i) begin
          rdat_next   = wb_dat_i;
          status_next = ST_OK;
          state_next  = S_RESP;
        end else if (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
          status_next = ST_ERR;
          state_next  = S_RESP;
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end
      S_RESP: begin
        // tx_busy rises one cycle after tx_start, so skip the launch cycle.
        if (!tx_busy && !tx_launched_reg) begin
          if (resp_idx_reg > resp_last) begin
            state_next = S_IDLE;
          end else begin
            tx_start         = 1'b1;
            tx_launched_next = 1'b1;
            resp_idx_next    = resp_idx_reg + RIDX_W'(1);
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      is_read_reg     <= 1'b0;
      byte_idx_reg    <= '0;
      adr_reg         <= '0;
      wdat_reg        <= '0;
      rdat_reg        <= '0;
      status_reg      <= '0;
      to_cnt_reg      <= '0;
      resp_idx_reg    <= '0;
      tx_launched_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      is_read_reg     <= is_read_next;
      byte_idx_reg    <= byte_idx_next;
      adr_reg         <= adr_next;
      wdat_reg        <= wdat_next;
      rdat_reg        <= rdat_next;
      status_reg      <= status_next;
      to_cnt_reg      <= to_cnt_next;
      resp_idx_reg    <= resp_idx_next;
      tx_launched_reg <= tx_launched_next;
    end
  end

  assign wb_cyc_o = (state_reg == S_BUS);
  assign wb_stb_o = (state_reg == S_BUS);
  assign wb_we_o  = (state_reg == S_BUS) && !is_read_reg;
  assign wb_sel_o = {DBYTES{state_reg == S_BUS}};
  assign wb_adr_o = adr_reg;
  assign wb_dat_o = wdat_reg;
  assign busy_o   = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_wb_master_bridge.sv
// Directed and randomized bench for uart_wb_master_bridge with a memory-model slave.
// Honours UART_WB_PARITY_EN when the same macro is defined for the whole build.
module tb_uart_wb_master_bridge;

  localparam int DW      = 32;
  localparam int AW      = 16;
  localparam int DB      = DW / 8;
  localparam int CLK_DIV = 8;
  localparam int TMO     = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          uart_rx = 1'b1;
  logic          uart_tx;
  logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, busy_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic [DB-1:0] wb_sel_o;

  always #5 clk = ~clk;

  uart_wb_master_bridge #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .CLK_DIV        (CLK_DIV),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .busy_o   (busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- Wishbone slave: memory with programmable ack latency
  int            ack_delay = 0;     // -1: never ack
  bit            force_en = 1'b0;
  logic [DW-1:0] force_rd = '0;
  int            wait_cnt = 0, stb_cycles = 0, cyc_starts = 0;
  logic          prev_cyc = 1'b0;
  logic [AW-1:0] seen_adr = '0;
  logic [DW-1:0] seen_dat = '0;
  logic          seen_we = 1'b0;
  logic [DB-1:0] seen_sel = '0;
  logic [DW-1:0] slave_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] slave_default(input logic [AW-1:0] a);
    return {~a, a};
  endfunction

  always @(negedge clk) begin
    if (wb_cyc_o && !prev_cyc) cyc_starts++;
    prev_cyc = wb_cyc_o;
    if (wb_cyc_o && wb_stb_o) begin
      stb_cycles++;
      seen_adr = wb_adr_o;
      seen_dat = wb_dat_o;
      seen_we  = wb_we_o;
      seen_sel = wb_sel_o;
      if (ack_delay >= 0 && wait_cnt == ack_delay) begin
        wb_ack_i = 1'b1;
        if (force_en) wb_dat_i = force_rd;
        else if (slave_mem.exists(wb_adr_o)) wb_dat_i = slave_mem[wb_adr_o];
        else wb_dat_i = slave_default(wb_adr_o);
        if (wb_we_o) slave_mem[wb_adr_o] = wb_dat_o;
      end else begin
        wb_ack_i = 1'b0;
        wb_dat_i = $urandom;
      end
      wait_cnt++;
    end else begin
      wb_ack_i = 1'b0;
      wait_cnt = 0;
    end
  end

  // ---------------- UART monitor on uart_tx
  logic [7:0] rx_q[$];
  int         frame_errs = 0;

  initial begin
    logic [7:0] b;
    @(posedge rst_n);
    forever begin
      @(negedge uart_tx);
      repeat (CLK_DIV / 2) @(posedge clk);
      if (uart_tx == 1'b0) begin
        b = '0;
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(posedge clk);
          b[i] = uart_tx;
        end
`ifdef UART_WB_PARITY_EN
        repeat (CLK_DIV) @(posedge clk);
        if (uart_tx !== ^b) frame_errs++;
`endif
        repeat (CLK_DIV) @(posedge clk);
        if (uart_tx !== 1'b1) frame_errs++;
        rx_q.push_back(b);
      end
    end
  end

  // ---------------- UART driver; flaw 1 = stop bit low, 2 = wrong parity
  task automatic send_byte(input logic [7:0] b, input int flaw);
    uart_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
`ifdef UART_WB_PARITY_EN
    uart_rx = (^b) ^ (flaw == 2);
    repeat (CLK_DIV) @(negedge clk);
`endif
    uart_rx = (flaw != 1);
    repeat (CLK_DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  int rx_rd = 0;

  // frm: bytes sent LSB-first; exp: reply bytes LSB-first.
  task automatic do_txn(input string tag, input logic [63:0] frm, input int flen,
                        input int flaw_idx, input int flaw,
                        input logic [39:0] exp, input int elen,
                        input int exp_cyc, input int exp_stb);
    int cs0 = cyc_starts;
    int sc0 = stb_cycles;
    int budget = (elen + flen + 2) * 14 * CLK_DIV + 2 * TMO + 200;
    int n;
    for (int i = 0; i < flen; i++) send_byte(frm[i*8 +: 8], (i == flaw_idx) ? flaw : 0);
    n = 0;
    while ((rx_q.size() - rx_rd) < elen && n < budget) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (busy_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, " busy_done"}, busy_o, 1'b0);
    repeat (4) @(negedge clk);
    check({tag, " reply_len"}, rx_q.size() - rx_rd, elen);
    for (int i = 0; i < elen; i++) begin
      if (rx_rd + i < rx_q.size())
        check($sformatf("%s reply[%0d]", tag, i), rx_q[rx_rd+i], exp[i*8 +: 8]);
    end
    rx_rd = rx_q.size();
    check({tag, " cyc_count"}, cyc_starts - cs0, exp_cyc);
    if (exp_stb >= 0) check({tag, " stb_cycles"}, stb_cycles - sc0, exp_stb);
    check({tag, " sel_idle"}, wb_sel_o, '0);
    $display("txn %s: sent %0d bytes, got %0d reply bytes, %0d bus cycles",
             tag, flen, elen, cyc_starts - cs0);
  endtask

  // ---------------- Behavioural reference model
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : slave_default(a);
  endfunction

  initial begin
    #800000;
    $display("FAIL watchdog: observed no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [AW-1:0] pool [6];
    bit            is_wr;
    int            dly;

    repeat (5) @(negedge clk);
    check("reset uart_tx", uart_tx, 1'b1);
    check("reset cyc", wb_cyc_o, 1'b0);
    check("reset stb", wb_stb_o, 1'b0);
    check("reset we", wb_we_o, 1'b0);
    check("reset sel", wb_sel_o, '0);
    check("reset busy", busy_o, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Directed write, ack after 3 cycles
    ack_delay = 3;
    do_txn("write", 64'h00DE_ADBE_EF12_3457, 7, -1, 0, 40'h4B, 1, 1, 4);
    check("write adr", seen_adr, 16'h1234);
    check("write dat", seen_dat, 32'hDEADBEEF);
    check("write we", seen_we, 1'b1);
    check("write sel", seen_sel, 4'hF);
    ref_mem[16'h1234] = 32'hDEADBEEF;

    // Directed read, slave returns CAFEF00D
    ack_delay = 0;
    force_en  = 1'b1;
    force_rd  = 32'hCAFEF00D;
    do_txn("read", 64'h0001_0052, 3, -1, 0, 40'hCA_FEF0_0D4B, 5, 1, 1);
    force_en = 1'b0;
    check("read adr", seen_adr, 16'h0100);
    check("read we", seen_we, 1'b0);

    // Timeout, then the bridge must still serve a read
    ack_delay = -1;
    do_txn("timeout", 64'h0001_0052, 3, -1, 0, 40'h45, 1, 1, TMO);
    ack_delay = 1;
    d = ref_read(16'h1234);
    do_txn("after_timeout", 64'h0012_3452, 3, -1, 0, {d, 8'h4B}, 5, 1, 2);

    // Unknown command
    do_txn("bad_cmd", 64'h41, 1, -1, 0, 40'h45, 1, 0, -1);

    // Stop bit low on the second address byte
    do_txn("bad_stop", 64'h0012_3457, 3, 2, 1, 40'h45, 1, 0, -1);

`ifdef UART_WB_PARITY_EN
    do_txn("bad_parity", 64'h0012_3452, 3, 1, 2, 40'h45, 1, 0, -1);
`endif

    // Reset in the middle of the data phase
    send_byte(8'h57, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    send_byte(8'hAA, 0);
    check("mid_data busy", busy_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst uart_tx", uart_tx, 1'b1);
    check("rst busy", busy_o, 1'b0);
    check("rst cyc", wb_cyc_o, 1'b0);
    check("rst stb", wb_stb_o, 1'b0);
    check("rst adr", wb_adr_o, '0);
    check("rst dat", wb_dat_o, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    ack_delay = 2;
    do_txn("post_reset_write", 64'h0044_3322_1156_7857, 7, -1, 0, 40'h4B, 1, 1, 3);
    check("post_reset adr", seen_adr, 16'h5678);
    check("post_reset dat", seen_dat, 32'h44332211);
    ref_mem[16'h5678] = 32'h44332211;

    // Randomized mix of writes and reads
    pool[0] = 16'h1234;
    pool[1] = 16'h5678;
    for (int i = 2; i < 6; i++) pool[i] = AW'($urandom);
    for (int t = 0; t < 12; t++) begin
      a     = pool[$urandom_range(0, 5)];
      d     = $urandom;
      is_wr = ($urandom_range(0, 1) == 1);
      dly   = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 6));
      ack_delay = dly;
      if (is_wr) begin
        do_txn($sformatf("rand%0d_wr_%h", t, a), {8'h00, d, a, 8'h57}, 7, -1, 0,
               (dly < 0) ? 40'h45 : 40'h4B, 1, 1, (dly < 0) ? TMO : dly + 1);
        check($sformatf("rand%0d dat", t), seen_dat, d);
        check($sformatf("rand%0d we", t), seen_we, 1'b1);
        if (dly >= 0) ref_mem[a] = d;
      end else begin
        if (dly < 0)
          do_txn($sformatf("rand%0d_rd_%h", t, a), {40'h0, a, 8'h52}, 3, -1, 0,
                 40'h45, 1, 1, TMO);
        else
          do_txn($sformatf("rand%0d_rd_%h", t, a), {40'h0, a, 8'h52}, 3, -1, 0,
                 {ref_read(a), 8'h4B}, 5, 1, dly + 1);
        check($sformatf("rand%0d we", t), seen_we, 1'b0);
      end
      check($sformatf("rand%0d adr", t), seen_adr, a);
    end

    check("uart frame errors", frame_errs, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_wb_master_bridge.md
Name: uart_wb_master_bridge

Overview:
Parametrised successor to the UART-to-Wishbone loader, with a real 8N1 UART receiver and transmitter in place of simulation stubs.
- Host sends framed commands over UART: single Wishbone write or read of one word, address and data widths set by parameters.
- Bridge runs the bus cycle with an ack timeout and returns a status byte, plus read data for reads.
- Sits between the board UART pins and the Wishbone bus of the core's instruction/data memories.

Parameters:
- DATA_WIDTH, 32, Wishbone data width; multiple of 8; DBYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 16, Wishbone address width; multiple of 8; ABYTES = ADDR_WIDTH/8.
- CLK_DIV, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 8.
- TIMEOUT_CYCLES, 1024, maximum cycles wb_stb_o stays high awaiting ack.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- uart_rx  in  1  UART receive line, idle high, asynchronous to clk
- uart_tx  out  1  UART transmit line, idle high
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_adr_o  out  ADDR_WIDTH  Wishbone address
- wb_dat_o  out  DATA_WIDTH  Wishbone write data
- wb_sel_o  out  DBYTES  byte select; all ones during any cycle, 0 otherwise
- wb_dat_i  in  DATA_WIDTH  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge
- busy_o  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (async, rst_n low):
  - uart_tx=1; all wb_* outputs and busy_o = 0.
  - FSM to IDLE; RX/TX shift state and counters cleared.
  - Applies immediately, mid-frame or mid-bus-cycle; a partial frame is lost and no response is sent.
- UART RX:
  - uart_rx passes through a 2-FF synchroniser.
  - Falling edge in idle starts a byte; the start bit is re-sampled at CLK_DIV/2 and a high sample aborts silently.
  - Data bits are sampled every CLK_DIV cycles from that point, LSB first, then the stop bit.
  - Stop=0 is a framing error.
  - A good byte pulses an internal rx_valid for 1 cycle.
- UART TX: start bit, 8 data bits LSB first, stop bit; each bit held CLK_DIV cycles.
- Frame format, little-endian fields:
  - Command byte: 0x57 'W' = write, 0x52 'R' = read.
  - Then ABYTES address bytes.
  - For 'W' only, then DBYTES data bytes.
- FSM states and transitions:
  - IDLE: rx_valid with 'W'/'R' -> ADDR. Any other command -> RESP with status 0x45 'E'.
  - ADDR: collect ABYTES bytes. 'R' -> BUS; 'W' -> DATA.
  - DATA: collect DBYTES bytes, then -> BUS.
  - BUS: in the first cycle, cyc/stb/sel assert and we=1 for 'W'. A cycle counter starts.
    - wb_ack_i high -> cyc/stb/we/sel drop at the next edge. Read data latches from wb_dat_i in the ack cycle. Status 0x4B 'K'. -> RESP.
    - Counter reaches TIMEOUT_CYCLES with no ack -> drop the cycle, status 'E', -> RESP.
  - RESP: transmit the status byte. For read with 'K', then transmit DBYTES data bytes LSB byte first. -> IDLE when the last stop bit completes.
- Framing error in ADDR/DATA: abandon the frame, no bus cycle, respond 'E'.
- Framing error in IDLE: ignored.
- Bytes completing while in BUS or RESP are discarded; there is no RX FIFO.
- ack arriving in the same cycle the timeout count expires counts as success.
- Counters wrap is impossible by construction: byte index is bounded by max(ABYTES, DBYTES); the timeout counter saturates.

Optional Feature:
- Macro UART_WB_PARITY_EN.
- Defined: an even parity bit follows the data bits on both RX and TX (11-bit frames). RX parity error is handled exactly like a framing error.
- Undefined: 8N1 only; no parity logic is generated.

Decomposition:
- Shared package uart_wb_pkg holds:
  - command constants CMD_WR = 8'h57, CMD_RD = 8'h52;
  - status constants ST_OK = 8'h4B, ST_ERR = 8'h45;
  - FSM state encoding.
- One sub-module is natural: uart_wb_phy.
  - Contains the synchroniser, RX and TX shifters, and baud counters.
  - Interface: rx_data/rx_valid/rx_err, tx_data/tx_start/tx_busy.
- The bridge FSM stays in the top.

Test Plan:
- Write: send 57 34 12 EF BE AD DE -> one cycle with adr=0x1234, dat=0xDEADBEEF, we=1, sel=0xF; ack after 3 cycles -> uart_tx returns 0x4B.
- Read: send 52 00 01; slave acks with 0xCAFEF00D -> uart_tx returns 4B 0D F0 FE CA.
- Timeout: read with ack tied low -> stb high exactly TIMEOUT_CYCLES cycles, then 0x45; next command still served.
- Bad command 0x41 -> 0x45 reply, no wb_cyc_o pulse.
- Stop bit forced 0 on the 2nd address byte -> no bus cycle, 0x45 reply.
- rst_n pulsed low mid-DATA -> uart_tx=1 and wb outputs 0 immediately; a fresh write frame then completes normally. With UART_WB_PARITY_EN, a corrupted parity bit -> 0x45 reply.
